// File: rtl/mem_responder.sv
// Single-port word-addressed RAM behind a valid/ready request port, with programmable wait states.
// Optional RESP_ERR_EN adds the mem_error port and out-of-range detection (otherwise indices alias).
module mem_responder #(
   parameter int unsigned DEPTH_LOG2  = 14,
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        mem_valid,
   input  logic        mem_instr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic [31:0] mem_rdata,
   output logic        mem_ready
`ifdef RESP_ERR_EN
   ,
   output logic        mem_error
`endif
);

   // state  | meaning
   // S_IDLE | waiting for mem_valid; request fields latched on acceptance
   // S_WAIT | counting down programmed wait states
   // S_RESP | mem_ready high for one cycle, RAM access completed on entry

   localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
   localparam bit          NO_WAIT = (WAIT_STATES == 0);
   localparam logic [3:0]  WS_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                state;
   logic [3:0]            cnt;
   logic [31:0]           lat_addr;
   logic [31:0]           lat_wdata;
   logic [3:0]            lat_wstrb;
   logic                  rd_sel;
   logic                  err_q;

   logic                  go_resp;
   logic [31:0]           acc_addr;
   logic [31:0]           acc_wdata;
   logic [3:0]            acc_wstrb;
   logic [31:0]           acc_off;
   logic [DEPTH_LOG2-1:0] acc_idx;
   logic                  acc_oor;

   logic [31:0]           ram [DEPTH];
   logic [31:0]           ram_q;
   logic                  unused_bits;

   // With no wait states the access happens on the acceptance edge, so the live request is used.
   always_comb begin
      go_resp   = 1'b0;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_wstrb = lat_wstrb;
      case (state)
         S_IDLE: begin
            if (mem_valid && NO_WAIT) begin
               go_resp   = 1'b1;
               acc_addr  = mem_addr;
               acc_wdata = mem_wdata;
               acc_wstrb = mem_wstrb;
            end
         end
         S_WAIT:  go_resp = (cnt == 4'd0);
         default: go_resp = 1'b0;
      endcase
   end

   assign acc_off = acc_addr - BASE_ADDR;
   assign acc_idx = acc_off[DEPTH_LOG2+1:2];

`ifdef RESP_ERR_EN
   assign acc_oor   = (acc_addr < BASE_ADDR) || ((acc_off >> (DEPTH_LOG2 + 2)) != 32'd0);
   assign mem_error = err_q;
`else
   assign acc_oor = 1'b0;
`endif

   assign unused_bits = ^{mem_instr, acc_off};

   // Gated by reset so a zero-wait write presented during reset never lands.
   always_ff @(posedge clock) begin
      if (go_resp && reset) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_wstrb[i] && !acc_oor) begin
               ram[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
         end
         ram_q <= ram[acc_idx];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         cnt       <= 4'd0;
         lat_addr  <= 32'd0;
         lat_wdata <= 32'd0;
         lat_wstrb <= 4'd0;
         mem_ready <= 1'b0;
         rd_sel    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         mem_ready <= 1'b0;
         rd_sel    <= 1'b0;
         err_q     <= 1'b0;
         case (state)
            S_IDLE: begin
               if (mem_valid) begin
                  lat_addr  <= mem_addr;
                  lat_wdata <= mem_wdata;
                  lat_wstrb <= mem_wstrb;
                  cnt       <= WS_LOAD;
                  state     <= NO_WAIT ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt == 4'd0) begin
                  state <= S_RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
         if (go_resp) begin
            mem_ready <= 1'b1;
            rd_sel    <= (acc_wstrb == 4'd0);
            err_q     <= acc_oor;
         end
      end
   end

   assign mem_rdata = rd_sel ? (err_q ? 32'hDEADBEEF : ram_q) : 32'd0;

endmodule
